instr_fetch_unit: RTL

Fetch stage placed directly upstream of the datapath. It owns the fetch PC and issues single-outstanding read requests to a variable-latency instruction memory. Returned halfwords are buffered in a small prefetch queue and handed to the datapath through a valid/ready handshake. Jump, beq and bne resolution in the datapath drives a redirect that flushes the queue and discards any in-flight response.

---
 rtl/instr_fetch_unit.sv | 79 +++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with a small prefetch queue
// and redirect-driven flush of queued and in-flight instructions.
module instr_fetch_unit #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;
   state_e        state_q;
   logic [15:0]   data_q [DEPTH];
   logic [15:0]   pc_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   fetch_pc_q, addr_q, last_instr_q, last_pc_q;
   logic          req_q, push, pop, issue;
   assign instr_valid = count_q != '0;
   assign pop         = instr_valid && instr_ready;
   assign push        = state_q == S_WAIT && imem_rvalid && !redirect;
   assign issue       = state_q == S_IDLE && count_q < (AW+1)'(DEPTH) && !redirect;
   assign count_d     = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   // an empty queue keeps presenting the last head it showed
   assign instr       = instr_valid ? data_q[rd_q] : last_instr_q;
   assign instr_pc    = instr_valid ? pc_q[rd_q] : last_pc_q;
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_q] <= imem_rdata;
         pc_q[wr_q]   <= addr_q;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rd_q         <= '0;
         wr_q         <= '0;
         count_q      <= '0;
         fetch_pc_q   <= RESET_PC;
         addr_q       <= '0;
         req_q        <= 1'b0;
         last_instr_q <= '0;
         last_pc_q    <= '0;
      end else begin
         count_q <= count_d;
         rd_q    <= redirect ? '0 : pop ? rd_q + AW'(1) : rd_q;
         wr_q    <= redirect ? '0 : push ? wr_q + AW'(1) : wr_q;
         req_q   <= issue;
         if (instr_valid) begin
            last_instr_q <= data_q[rd_q];
            last_pc_q    <= pc_q[rd_q];
         end
         if (issue) begin
            addr_q     <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 16'd2;
         end
         if (redirect) fetch_pc_q <= {redirect_pc[15:1], 1'b0};
         // a response in the redirect cycle still retires the outstanding request
         case (state_q)
            S_IDLE:  state_q <= issue ? S_WAIT : S_IDLE;
            S_WAIT:  state_q <= imem_rvalid ? S_IDLE : redirect ? S_DROP : S_WAIT;
            S_DROP:  state_q <= imem_rvalid ? S_IDLE : S_DROP;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
